// File: rtl/dma_c2h_gen_pkg.sv
// Shared constants and types for the C2H AXI-Stream packet generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dma_c2h_gen_pkg;

    localparam int DATA_W         = 512;
    localparam int KEEP_W         = 64;
    localparam int WORDS_PER_BEAT = 32;

    // Sideband word carried unchanged on every beat except for sop.
    typedef struct packed {
        logic [35:0] rsvd;
        logic        sop;
        logic [10:0] qid;
        logic [15:0] len;
    } c2h_tusr_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsm_e;

endpackage

// File: rtl/dma_c2h_beat_fmt.sv
// Combinational beat formatter: incrementing 16-bit pattern, last-beat keep, byte parity.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers and holds the result.
//
// Ports: seed/beat select the pattern, last/rem select the byte-enable mask,
// tdata/tkeep/tparity are the formatted beat with masked bytes forced to zero.
module dma_c2h_beat_fmt
    import dma_c2h_gen_pkg::*;
(
    input  logic [15:0]       seed,
    input  logic [9:0]        beat,
    input  logic              last,
    input  logic [5:0]        rem,
    output logic [DATA_W-1:0] tdata,
    output logic [KEEP_W-1:0] tkeep,
    output logic [KEEP_W-1:0] tparity
);

    logic [15:0]       base;
    logic [DATA_W-1:0] raw;

    // Each beat carries 32 words, so beat b starts 32*b past the seed.
    assign base = seed + 16'({beat, 5'b0_0000});

    always_comb begin
        tkeep = '1;
        // rem==0 on the last beat means it is completely filled.
        if (last && (rem != 6'd0)) begin
            tkeep = (KEEP_W'(1) << rem) - KEEP_W'(1);
        end
        raw = '0;
        for (int k = 0; k < WORDS_PER_BEAT; k++) begin
            raw[16*k +: 16] = base + 16'(k);
        end
        tdata   = '0;
        tparity = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            tdata[8*i +: 8] = tkeep[i] ? raw[8*i +: 8] : 8'h00;
            tparity[i]      = ^raw[8*i +: 8] & tkeep[i];
        end
    end

endmodule

// File: rtl/dma_c2h_axis_pkt_gen.sv
// Command-driven C2H AXIS source: one packet of cmd_len bytes per accepted command.
// Latency: first beat valid the cycle after command acceptance; one beat per tready.
// Backpressure: output register holds while tvalid & !tready; cmd_rdy low while sending.
//
// Ports: cmd_* command channel, c2h_* 512-bit AXIS master, err_zero_len pulse on a
// dropped zero-length command, pkt_cnt completed-packet counter, busy while sending.
module dma_c2h_axis_pkt_gen #(
    parameter int DATA_W = 512,
    parameter int QID_W  = 11,
    parameter int CNT_W  = 32
) (
    input  logic              user_clk,
    input  logic              user_reset,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [QID_W-1:0]  cmd_qid,
    input  logic [15:0]       cmd_len,
    input  logic [15:0]       cmd_seed,
    output logic [DATA_W-1:0] c2h_tdata,
    output logic [63:0]       c2h_tparity,
    output logic              c2h_tlast,
    output logic              c2h_tvalid,
    output logic [63:0]       c2h_tkeep,
    output logic [63:0]       c2h_tusr,
    input  logic              c2h_tready,
    output logic              err_zero_len,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              busy
);

    import dma_c2h_gen_pkg::*;

    fsm_e             state;
    logic [QID_W-1:0] qid_q;
    logic [15:0]      len_q;
    logic [15:0]      seed_q;
    logic [9:0]       beat_q;
    logic [9:0]       last_beat_q;

    logic             accept;
    logic [9:0]       cmd_last_beat;

    logic [15:0]      fmt_seed;
    logic [9:0]       fmt_beat;
    logic             fmt_last;
    logic [5:0]       fmt_rem;
    logic [511:0]     fmt_tdata;
    logic [63:0]      fmt_tkeep;
    logic [63:0]      fmt_tparity;
    c2h_tusr_t        nxt_tusr;

    assign accept        = cmd_vld & cmd_rdy;
    // Index of the final beat, i.e. ceil(len/64)-1; only meaningful for len != 0.
    assign cmd_last_beat = 10'((cmd_len - 16'd1) >> 6);
    assign busy          = (state == SEND);

    // In IDLE the formatter builds beat 0 straight from the command so it can be
    // registered on the accepting edge; in SEND it builds the following beat.
    always_comb begin
        if (state == IDLE) begin
            fmt_seed = cmd_seed;
            fmt_beat = 10'd0;
            fmt_last = (cmd_last_beat == 10'd0);
            fmt_rem  = cmd_len[5:0];
        end else begin
            fmt_seed = seed_q;
            fmt_beat = beat_q + 10'd1;
            fmt_last = ((beat_q + 10'd1) == last_beat_q);
            fmt_rem  = len_q[5:0];
        end
        nxt_tusr      = '0;
        nxt_tusr.sop  = (state == IDLE);
        nxt_tusr.qid  = (state == IDLE) ? 11'(cmd_qid) : 11'(qid_q);
        nxt_tusr.len  = (state == IDLE) ? cmd_len : len_q;
    end

    dma_c2h_beat_fmt u_fmt (
        .seed    (fmt_seed),
        .beat    (fmt_beat),
        .last    (fmt_last),
        .rem     (fmt_rem),
        .tdata   (fmt_tdata),
        .tkeep   (fmt_tkeep),
        .tparity (fmt_tparity)
    );

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state        <= IDLE;
            cmd_rdy      <= 1'b0;
            qid_q        <= '0;
            len_q        <= '0;
            seed_q       <= '0;
            beat_q       <= '0;
            last_beat_q  <= '0;
            c2h_tdata    <= '0;
            c2h_tparity  <= '0;
            c2h_tlast    <= 1'b0;
            c2h_tvalid   <= 1'b0;
            c2h_tkeep    <= '0;
            c2h_tusr     <= '0;
            err_zero_len <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            err_zero_len <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_rdy <= 1'b1;
                    if (accept) begin
                        if (cmd_len == 16'd0) begin
                            err_zero_len <= 1'b1;
                        end else begin
                            state       <= SEND;
                            cmd_rdy     <= 1'b0;
                            qid_q       <= cmd_qid;
                            len_q       <= cmd_len;
                            seed_q      <= cmd_seed;
                            beat_q      <= 10'd0;
                            last_beat_q <= cmd_last_beat;
                            c2h_tvalid  <= 1'b1;
                            c2h_tdata   <= fmt_tdata;
                            c2h_tkeep   <= fmt_tkeep;
                            c2h_tparity <= fmt_tparity;
                            c2h_tlast   <= fmt_last;
                            c2h_tusr    <= nxt_tusr;
                        end
                    end
                end
                SEND: begin
                    // tvalid is always high in SEND, so advancing on tready alone
                    // is the same as advancing on !tvalid | tready.
                    if (c2h_tvalid && c2h_tready) begin
                        if (c2h_tlast) begin
                            state       <= IDLE;
                            cmd_rdy     <= 1'b1;
                            pkt_cnt     <= pkt_cnt + CNT_W'(1);
                            c2h_tvalid  <= 1'b0;
                            c2h_tlast   <= 1'b0;
                            c2h_tdata   <= '0;
                            c2h_tkeep   <= '0;
                            c2h_tparity <= '0;
                            c2h_tusr    <= '0;
                        end else begin
                            beat_q      <= beat_q + 10'd1;
                            c2h_tdata   <= fmt_tdata;
                            c2h_tkeep   <= fmt_tkeep;
                            c2h_tparity <= fmt_tparity;
                            c2h_tlast   <= fmt_last;
                            c2h_tusr    <= nxt_tusr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_c2h_axis_pkt_gen.sv
// Directed self-checking bench for the C2H AXIS packet generator.
// Latency: n/a.
// Backpressure: exercised through c2h_tready stalls.
module tb_dma_c2h_axis_pkt_gen;

    logic          user_clk = 1'b0;
    logic          user_reset;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [10:0]   cmd_qid;
    logic [15:0]   cmd_len;
    logic [15:0]   cmd_seed;
    logic [511:0]  c2h_tdata;
    logic [63:0]   c2h_tparity;
    logic          c2h_tlast;
    logic          c2h_tvalid;
    logic [63:0]   c2h_tkeep;
    logic [63:0]   c2h_tusr;
    logic          c2h_tready;
    logic          err_zero_len;
    logic [31:0]   pkt_cnt;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 user_clk = ~user_clk;

    dma_c2h_axis_pkt_gen dut (
        .user_clk     (user_clk),
        .user_reset   (user_reset),
        .cmd_vld      (cmd_vld),
        .cmd_rdy      (cmd_rdy),
        .cmd_qid      (cmd_qid),
        .cmd_len      (cmd_len),
        .cmd_seed     (cmd_seed),
        .c2h_tdata    (c2h_tdata),
        .c2h_tparity  (c2h_tparity),
        .c2h_tlast    (c2h_tlast),
        .c2h_tvalid   (c2h_tvalid),
        .c2h_tkeep    (c2h_tkeep),
        .c2h_tusr     (c2h_tusr),
        .c2h_tready   (c2h_tready),
        .err_zero_len (err_zero_len),
        .pkt_cnt      (pkt_cnt),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a command from a negedge; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [10:0] qid, input logic [15:0] len, input logic [15:0] seed);
        int n = 0;
        @(negedge user_clk);
        cmd_vld  = 1'b1;
        cmd_qid  = qid;
        cmd_len  = len;
        cmd_seed = seed;
        while (!cmd_rdy && n < 50) begin
            @(negedge user_clk);
            n++;
        end
        if (!cmd_rdy) chk("cmd_rdy_timeout", 64'd0, 64'd1);
        @(negedge user_clk);
        cmd_vld = 1'b0;
    endtask

    // Check the beat currently presented against the pattern definition, then
    // accept it and move to the next negedge.
    task automatic check_beat(input string tag, input logic [15:0] seed, input logic [15:0] len,
                              input logic [10:0] qid, input int b);
        logic [511:0] ed;
        logic [63:0]  ek;
        logic [63:0]  ep;
        logic [63:0]  eu;
        int           nb;
        int           rem;
        logic         last;
        nb   = (int'(len) + 63) / 64;
        rem  = int'(len) % 64;
        last = (b == nb - 1);
        ek   = '1;
        if (last && rem != 0) ek = (64'h1 << rem) - 64'h1;
        for (int k = 0; k < 32; k++) ed[16*k +: 16] = seed + 16'(32*b + k);
        for (int i = 0; i < 64; i++) begin
            if (!ek[i]) ed[8*i +: 8] = 8'h00;
            ep[i] = ^ed[8*i +: 8];
        end
        eu = {36'd0, (b == 0), qid, len};
        chk($sformatf("%s_b%0d_tvalid", tag, b), 64'(c2h_tvalid), 64'd1);
        chk($sformatf("%s_b%0d_tlast", tag, b), 64'(c2h_tlast), 64'(last));
        chk($sformatf("%s_b%0d_tkeep", tag, b), c2h_tkeep, ek);
        chk($sformatf("%s_b%0d_tusr", tag, b), c2h_tusr, eu);
        chk($sformatf("%s_b%0d_tparity", tag, b), c2h_tparity, ep);
        for (int c = 0; c < 8; c++)
            chk($sformatf("%s_b%0d_tdata%0d", tag, b, c), c2h_tdata[64*c +: 64], ed[64*c +: 64]);
        c2h_tready = 1'b1;
        @(negedge user_clk);
    endtask

    logic [511:0] snap_d;
    logic [63:0]  snap_k, snap_p, snap_u;
    logic         snap_l;
    int           nbeats;

    initial begin
        user_reset = 1'b1;
        cmd_vld    = 1'b0;
        cmd_qid    = '0;
        cmd_len    = '0;
        cmd_seed   = '0;
        c2h_tready = 1'b1;

        // Reset state
        repeat (3) @(negedge user_clk);
        chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        chk("rst_tvalid", 64'(c2h_tvalid), 64'd0);
        chk("rst_tusr", c2h_tusr, 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_zero_len), 64'd0);
        user_reset = 1'b0;
        @(negedge user_clk);
        chk("post_rst_cmd_rdy", 64'(cmd_rdy), 64'd1);

        // len=64 seed=0: single full beat
        send_cmd(11'd0, 16'd64, 16'h0000);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_cmd_rdy", 64'(cmd_rdy), 64'd0);
        chk("t1_word31", 64'(c2h_tdata[511:496]), 64'h001F);
        chk("t1_tusr_hand", c2h_tusr, 64'h0000_0000_0800_0040);
        check_beat("t1", 16'h0000, 16'd64, 11'd0, 0);
        chk("t1_tvalid_drop", 64'(c2h_tvalid), 64'd0);
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // len=100 seed=0x1000: two beats, partial last
        send_cmd(11'd5, 16'd100, 16'h1000);
        check_beat("t2", 16'h1000, 16'd100, 11'd5, 0);
        chk("t2_b1_word0", 64'(c2h_tdata[15:0]), 64'h1020);
        chk("t2_b1_keep_hand", c2h_tkeep, 64'h0000_000F_FFFF_FFFF);
        chk("t2_b1_hi_zero", 64'(c2h_tdata[511:288] == '0), 64'd1);
        chk("t2_b1_hi_par", 64'(c2h_tparity[63:36]), 64'd0);
        chk("t2_b1_tusr_hand", c2h_tusr, 64'h0000_0000_0005_0064);
        check_beat("t2", 16'h1000, 16'd100, 11'd5, 1);
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // seed=0xFFF0: pattern wraps mid-beat
        send_cmd(11'd1, 16'd64, 16'hFFF0);
        chk("t3_word15", 64'(c2h_tdata[255:240]), 64'hFFFF);
        chk("t3_word16", 64'(c2h_tdata[271:256]), 64'h0000);
        chk("t3_par_byte30", 64'(c2h_tparity[30]), 64'd0);
        chk("t3_par_byte0", 64'(c2h_tparity[0]), 64'd0);
        chk("t3_par_byte2", 64'(c2h_tparity[2]), 64'd1);
        check_beat("t3", 16'hFFF0, 16'd64, 11'd1, 0);
        chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd3);

        // len=200 with a 5-cycle stall on beat 1
        send_cmd(11'd3, 16'd200, 16'h0100);
        check_beat("t4", 16'h0100, 16'd200, 11'd3, 0);
        c2h_tready = 1'b0;
        snap_d = c2h_tdata;
        snap_k = c2h_tkeep;
        snap_p = c2h_tparity;
        snap_u = c2h_tusr;
        snap_l = c2h_tlast;
        for (int s = 0; s < 5; s++) begin
            @(negedge user_clk);
            chk($sformatf("t4_stall%0d_tvalid", s), 64'(c2h_tvalid), 64'd1);
            chk($sformatf("t4_stall%0d_hold", s),
                64'((c2h_tdata == snap_d) && (c2h_tkeep == snap_k) && (c2h_tparity == snap_p)
                    && (c2h_tusr == snap_u) && (c2h_tlast == snap_l)), 64'd1);
        end
        check_beat("t4", 16'h0100, 16'd200, 11'd3, 1);
        check_beat("t4", 16'h0100, 16'd200, 11'd3, 2);
        chk("t4_b3_keep_hand", c2h_tkeep, 64'h0000_0000_0000_00FF);
        check_beat("t4", 16'h0100, 16'd200, 11'd3, 3);
        chk("t4_tvalid_drop", 64'(c2h_tvalid), 64'd0);
        chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd4);

        // zero-length command is dropped
        send_cmd(11'd2, 16'd0, 16'h1234);
        chk("t5_err_pulse", 64'(err_zero_len), 64'd1);
        chk("t5_tvalid", 64'(c2h_tvalid), 64'd0);
        chk("t5_cmd_rdy", 64'(cmd_rdy), 64'd1);
        @(negedge user_clk);
        chk("t5_err_clear", 64'(err_zero_len), 64'd0);
        chk("t5_tvalid_after", 64'(c2h_tvalid), 64'd0);
        chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd4);

        // maximum length: 1024 beats, last keep has 63 bytes
        send_cmd(11'd9, 16'hFFFF, 16'h0000);
        nbeats = 0;
        while (nbeats < 2000 && !(c2h_tvalid && c2h_tlast)) begin
            if (c2h_tvalid) nbeats++;
            @(negedge user_clk);
        end
        chk("t6_beats_before_last", 64'(nbeats), 64'd1023);
        chk("t6_last_keep_hand", c2h_tkeep, 64'h7FFF_FFFF_FFFF_FFFF);
        check_beat("t6", 16'h0000, 16'hFFFF, 11'd9, 1023);
        chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd5);

        // reset during beat 2 of a 4-beat packet
        send_cmd(11'd4, 16'd256, 16'h2000);
        check_beat("t7", 16'h2000, 16'd256, 11'd4, 0);
        check_beat("t7", 16'h2000, 16'd256, 11'd4, 1);
        chk("t7_b2_tvalid", 64'(c2h_tvalid), 64'd1);
        user_reset = 1'b1;
        @(negedge user_clk);
        chk("t7_rst_tvalid", 64'(c2h_tvalid), 64'd0);
        chk("t7_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("t7_rst_busy", 64'(busy), 64'd0);
        chk("t7_rst_tdata", c2h_tdata[63:0], 64'd0);
        chk("t7_rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        user_reset = 1'b0;
        send_cmd(11'd7, 16'd64, 16'h0042);
        chk("t7_new_tusr_hand", c2h_tusr, 64'h0000_0000_0807_0040);
        check_beat("t7n", 16'h0042, 16'd64, 11'd7, 0);
        chk("t7_new_pkt_cnt", 64'(pkt_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_c2h_axis_pkt_gen.md
Name: dma_c2h_axis_pkt_gen

Overview:
Command-driven C2H stream source sitting directly upstream of the 512-bit C2H AXI-Stream port (master side of the C2H AXIS interface). Each accepted command produces one packet of programmable byte length, filled with a seeded 16-bit incrementing pattern. The block generates per-byte parity, last-beat tkeep and a tusr sideband word. Used as the C2H traffic source in the QDMA example design and bench.

Parameters:
DATA_W, 512, stream data width in bits; fixed, other values unsupported.
QID_W, 11, queue-id width.
CNT_W, 32, completed-packet counter width.

Ports:
user_clk  in  1  sole clock
user_reset  in  1  reset, synchronous to user_clk and active-high
cmd_vld  in  1  command valid
cmd_rdy  out  1  command ready
cmd_qid  in  QID_W  target queue
cmd_len  in  16  packet length in bytes; 0 is illegal
cmd_seed  in  16  first pattern word
c2h_tdata  out  512  stream data
c2h_tparity  out  64  per-byte parity
c2h_tlast  out  1  last beat of packet
c2h_tvalid  out  1  beat valid
c2h_tkeep  out  64  byte enables
c2h_tusr  out  64  sideband
c2h_tready  in  1  downstream ready
err_zero_len  out  1  one-cycle pulse when a zero-length command is dropped
pkt_cnt  out  CNT_W  completed packets; wraps
busy  out  1  high in SEND

Behaviour:
- Interface: one clock, user_clk. Reset is synchronous and active-high (user_reset).
- Reset values: cmd_rdy=0; all c2h_* outputs=0; err_zero_len=0; pkt_cnt=0; busy=0; FSM=IDLE. cmd_rdy rises on the first cycle after reset deasserts.
- FSM IDLE: cmd_rdy=1. On cmd_vld&cmd_rdy:
  - cmd_len==0: drop the command, pulse err_zero_len on the next cycle, stay in IDLE.
  - cmd_len!=0: latch qid/len/seed, set beats=ceil(len/64) and beat index b=0, go to SEND.
  - First beat is presented (tvalid=1) on the cycle after acceptance.
- FSM SEND: cmd_rdy=0, busy=1.
  - Output register advances when !tvalid | tready.
  - On tvalid&tready&tlast: tvalid drops next cycle, pkt_cnt increments, return to IDLE.
  - Inter-packet gap is at least one cycle.
- AXIS rules: while tvalid=1 and tready=0, tdata/tkeep/tparity/tlast/tusr must hold stable. tvalid never drops without a handshake, except on reset.
- Data: 16-bit word k (bits 16k+15:16k, k=0..31) of beat b = (seed + 32*b + k) mod 2^16.
- Partial last beat: bytes with tkeep=0 are forced to 0x00.
- tkeep: all ones on non-last beats. On the last beat, all ones if len%64==0, else (1<<(len%64))-1.
- tparity[i] = XOR of c2h_tdata[8i+7:8i] (even parity), so masked bytes give 0.
- tusr, identical on every beat of a packet:
  - [15:0] len
  - [26:16] qid
  - [27] sop, set on beat 0 only
  - [63:28] zero
- Reset mid-packet: every output returns to its reset value on the cycle after user_reset is sampled high. The partial packet is abandoned and pkt_cnt is cleared.
- cmd_len=65535: 1024 beats, last tkeep = 63 low bits set.

Decomposition:
- Package dma_c2h_gen_pkg holds:
  - DATA_W=512, KEEP_W=64, WORDS_PER_BEAT=32
  - packed struct c2h_tusr_t {rsvd[35:0], sop, qid[10:0], len[15:0]}
  - FSM enum {IDLE, SEND}
- Sub-module dma_c2h_beat_fmt: purely combinational formatter. Takes seed, b, last and len%64; produces tdata, tkeep, tparity. The top level keeps the FSM, counters and output register.

Test Plan:
- len=64, seed=0x0000, tready=1 -> one beat with tlast=1, tkeep=all ones, word31=0x001F, tusr=0x0000_0000_0800_0040 (qid=0), pkt_cnt=1.
- len=100, seed=0x1000 -> two beats. Beat1 word0=0x1020, tkeep=0x0000_000F_FFFF_FFFF, bytes 36..63 zero with their parity 0, sop=0 on beat1.
- seed=0xFFF0, len=64 -> word15=0xFFFF, word16=0x0000 (wrap). Parity bits match the XOR of each byte.
- len=200 with tready held low for 5 cycles during beat1 -> beat1 outputs stable throughout, no beat lost or duplicated, 4 beats total.
- cmd_len=0 -> err_zero_len high exactly 1 cycle, tvalid stays 0, pkt_cnt unchanged, cmd_rdy stays 1.
- user_reset asserted during beat 2 of a 4-beat packet -> next cycle tvalid=0, pkt_cnt=0. A new len=64 command afterwards produces a clean packet with sop=1.
